pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg_pkg.sv | 13 +
 rtl/pipe_skid_reg_regwen.sv | 29 ++
 rtl/pipe_skid_reg.sv | 119 +++++++++++
 tb/tb_pipe_skid_reg.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline package: skid-register state encoding.
// Imported by the skid register and its storage cells.
package pipe_skid_reg_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_t;

   localparam int OCC_W = 2;

endpackage

// File: rtl/pipe_skid_reg_regwen.sv
// RegWEn: WIDTH-bit register with load enable and
// async active-low reset to RST_VAL.
// Ports: clk, rst_n, i_en, i_d -> o_q.
module RegWEn
   import pipe_skid_reg_pkg::*;
#(
   parameter int             WIDTH   = 32,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= RST_VAL;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register with fully registered in_ready.
// Ports: clk, rst(n), in_valid/in_ready/in_data, flush,
//        out_valid/out_ready/out_data, occ (0..2).
module pipe_skid_reg
   import pipe_skid_reg_pkg::*;
#(
   parameter int               WIDTH   = 32,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [OCC_W-1:0] occ
);

   skid_state_t r_state;
   skid_state_t w_state_nxt;

   logic             w_acc;
   logic             w_con;
   logic             w_main_en;
   logic             w_skid_en;
   logic [WIDTH-1:0] w_main_d;
   logic [WIDTH-1:0] w_skid_d;
   logic [WIDTH-1:0] w_main_q;
   logic [WIDTH-1:0] w_skid_q;

   // Handshake flags come from state only, so in_ready never
   // sees out_ready or in_valid combinationally.
   assign in_ready  = (r_state != ST_TWO);
   assign out_valid = (r_state != ST_EMPTY);
   assign out_data  = w_main_q;
   assign occ       = r_state;

   assign w_acc = in_valid & in_ready;
   assign w_con = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_main_en   = 1'b0;
      w_skid_en   = 1'b0;
      w_main_d    = in_data;
      w_skid_d    = in_data;
      if (flush) begin
         // Kill wins over any same-cycle accept or consume.
         w_state_nxt = ST_EMPTY;
         w_main_en   = 1'b1;
         w_skid_en   = 1'b1;
         w_main_d    = RST_VAL;
         w_skid_d    = RST_VAL;
      end else begin
         unique case (r_state)
            ST_EMPTY: begin
               if (w_acc) begin
                  w_main_en   = 1'b1;
                  w_state_nxt = ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_acc && w_con) begin
                  w_main_en = 1'b1;
               end else if (w_acc) begin
                  w_skid_en   = 1'b1;
                  w_state_nxt = ST_TWO;
               end else if (w_con) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (w_con) begin
                  w_main_en   = 1'b1;
                  w_main_d    = w_skid_q;
                  w_state_nxt = ST_ONE;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   RegWEn #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
   ) u_main (
      .clk   (clk),
      .rst_n (rst),
      .i_en  (w_main_en),
      .i_d   (w_main_d),
      .o_q   (w_main_q)
   );

   RegWEn #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
   ) u_skid (
      .clk   (clk),
      .rst_n (rst),
      .i_en  (w_skid_en),
      .i_d   (w_skid_d),
      .o_q   (w_skid_q)
   );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed cases
// followed by random traffic against a queue model.
module tb_pipe_skid_reg;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  occ;

   int total;
   int bad;

   logic [31:0] q[$];
   bit          clr;

   pipe_skid_reg #(
      .WIDTH   (32),
      .RST_VAL (32'h0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occ       (occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag);
      logic [31:0] sz;
      sz = q.size();
      chk({tag, ".occ"}, {30'd0, occ}, sz);
      chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, sz != 0});
      chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, sz < 2});
      if (sz != 0) begin
         chk({tag, ".out_data"}, out_data, q[0]);
      end else if (clr) begin
         chk({tag, ".out_data_rst"}, out_data, 32'h0);
      end
   endtask

   // One cycle: check outputs, drive inputs, confirm in_ready
   // ignores the new inputs, then advance the queue model.
   task automatic step(input string tag,
                       input logic iv,
                       input logic [31:0] d,
                       input logic ordy,
                       input logic fl);
      bit acc;
      bit con;
      @(negedge clk);
      chk_out(tag);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      #1;
      chk({tag, ".rdy_stable"}, {31'd0, in_ready},
          {31'd0, q.size() < 2});
      @(posedge clk);
      if (fl) begin
         q.delete();
         clr = 1'b1;
      end else begin
         con = (q.size() != 0) && ordy;
         acc = iv && (q.size() < 2);
         if (con) void'(q.pop_front());
         if (acc) begin
            q.push_back(d);
            clr = 1'b0;
         end
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      clr       = 1'b1;
      rst       = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hDEADBEEF;
      out_ready = 1'b0;
      flush     = 1'b0;

      // Reset holds everything empty despite an offered word.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_out("reset");
      rst      = 1'b1;
      in_valid = 1'b0;

      // Streaming: one word per cycle, never stalls.
      step("str0", 1'b1, 32'd1, 1'b1, 1'b0);
      step("str1", 1'b1, 32'd2, 1'b1, 1'b0);
      step("str2", 1'b1, 32'd3, 1'b1, 1'b0);
      step("str3", 1'b1, 32'd4, 1'b1, 1'b0);
      step("str4", 1'b0, 32'd0, 1'b1, 1'b0);
      step("str5", 1'b0, 32'd0, 1'b1, 1'b0);

      // Backpressure fills both entries, then drains in order.
      step("bp0", 1'b1, 32'hA, 1'b0, 1'b0);
      step("bp1", 1'b1, 32'hB, 1'b0, 1'b0);
      step("bp2", 1'b1, 32'hF00D, 1'b0, 1'b0);
      step("bp3", 1'b0, 32'h0, 1'b1, 1'b0);
      step("bp4", 1'b0, 32'h0, 1'b1, 1'b0);
      step("bp5", 1'b0, 32'h0, 1'b1, 1'b0);

      // Flush while full drops the held pair and the offer.
      step("fl0", 1'b1, 32'h11, 1'b0, 1'b0);
      step("fl1", 1'b1, 32'h22, 1'b0, 1'b0);
      step("fl2", 1'b1, 32'hC, 1'b1, 1'b1);
      step("fl3", 1'b0, 32'h0, 1'b1, 1'b0);
      step("fl4", 1'b0, 32'h0, 1'b1, 1'b0);

      // Reset pulse between edges while full.
      step("mr0", 1'b1, 32'h33, 1'b0, 1'b0);
      step("mr1", 1'b1, 32'h44, 1'b0, 1'b0);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst       = 1'b0;
      #1;
      q.delete();
      clr = 1'b1;
      chk_out("mrst");
      #1 rst = 1'b1;
      step("mr2", 1'b1, 32'h5, 1'b0, 1'b0);
      step("mr3", 1'b0, 32'h0, 1'b1, 1'b0);
      step("mr4", 1'b0, 32'h0, 1'b1, 1'b0);

      // Random traffic with occasional flushes.
      for (int i = 0; i < 10000; i++) begin
         step("rnd",
              1'($urandom_range(0, 1)),
              $urandom,
              1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 63) == 0));
      end
      step("end", 1'b0, 32'h0, 1'b1, 1'b0);
      step("end", 1'b0, 32'h0, 1'b1, 1'b0);
      step("end", 1'b0, 32'h0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
